// File: rtl/pix_fifo_mc_if.sv
// pix_fifo_mc_if: bus between the pixel writer / reader side and pix_fifo_mc.
//
// Ports (carried signals):
//   flush        writer -> fifo  synchronous clear of contents and error flags
//   wr_en        writer -> fifo  write request
//   wr_data      writer -> fifo  NCH*DW pixel, channel k at [k*DW +: DW]
//   rd_en        reader -> fifo  pop request
//   thresh       ctrl   -> fifo  almost-full threshold (AW+1 bits)
//   err_clr      ctrl   -> fifo  clears overflow / underflow
//   rd_data      fifo   -> reader head entry, first-word fall-through, 0 when empty
//   level        fifo   -> ctrl   stored entries, 0..DEPTH
//   full, empty, almost_full     fifo status
//   overflow, underflow          sticky error flags
//
// master: the side driving requests (writer/reader/control).
// slave : the FIFO itself.

interface pix_fifo_mc_if #(
  parameter int DW    = 8,
  parameter int NCH   = 3,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic              flush;
  logic              wr_en;
  logic [NCH*DW-1:0] wr_data;
  logic              rd_en;
  logic [AW:0]       thresh;
  logic              err_clr;
  logic [NCH*DW-1:0] rd_data;
  logic [AW:0]       level;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en, thresh, err_clr,
    input  rd_data, level, full, empty, almost_full, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, thresh, err_clr,
    output rd_data, level, full, empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/pix_fifo_mc.sv
// pix_fifo_mc: multi-channel pixel FIFO with shared pointers.
//
// All colour channels are stored in parallel per-channel arrays addressed by a
// single write/read pointer pair, so the components of one pixel always leave
// the FIFO together. First-word fall-through: the head entry is presented on
// rd_data combinationally; rd_data is forced to zero while empty.
//
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset (pointers and flags only;
//                storage is not reset)
//   bus      pix_fifo_mc_if.slave, see the interface file for signal list
//
// Pointers are AW+1 bits; the extra MSB is a wrap bit that distinguishes
// full (low bits equal, MSBs differ) from empty (fully equal). level is the
// modular difference of the pointers, so it naturally ranges 0..DEPTH.
// DEPTH must be a power of two and at least 2.

module pix_fifo_mc #(
  parameter int DW    = 8,
  parameter int NCH   = 3,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          reset_n,
  pix_fifo_mc_if.slave bus
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          we;
  logic          re;
  logic          ovf_set;
  logic          unf_set;
  logic          overflow_q;
  logic          underflow_q;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Status is purely combinational from the registered pointers.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

  // A write into a full FIFO is legal when the head is popped in the same
  // cycle: the freed slot is the one the write pointer addresses. Flush
  // suppresses both transfers.
  assign we = bus.wr_en & (~full | bus.rd_en) & ~bus.flush;
  assign re = bus.rd_en & ~empty & ~bus.flush;

  assign ovf_set = bus.wr_en & full & ~bus.rd_en;
  assign unf_set = bus.rd_en & empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + PTR_ONE;
      if (re) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Sticky errors: a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set)          overflow_q <= 1'b1;
      else if (bus.err_clr) overflow_q <= 1'b0;
      if (unf_set)          underflow_q <= 1'b1;
      else if (bus.err_clr) underflow_q <= 1'b0;
    end
  end

  // Per-channel storage; every channel uses the same indices.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) mem[wr_idx] <= bus.wr_data[k*DW +: DW];
    end

    assign bus.rd_data[k*DW +: DW] = empty ? '0 : mem[rd_idx];
  end

  assign bus.level       = level;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (level >= bus.thresh);
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule
